// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for receiver and transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    localparam int OVERSAMPLE       = 8;
    localparam int MID_SAMPLE       = 3;
    localparam int TICK_DIV_DEFAULT = 43;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick divider
module uart_baud_tick #(
    parameter int TICK_DIV = 43
) (
    input  logic user_clock,
    input  logic rst,
    output logic tick
);

    localparam logic [7:0] LP_WRAP = 8'(TICK_DIV - 1);

    logic [7:0] r_cnt;
    logic       r_tick;

    // Count 0..TICK_DIV-1 and flag the wrap with a one-cycle registered tick
    always_ff @(posedge user_clock or negedge rst) begin
        if (!rst) begin
            r_cnt  <= 8'd0;
            r_tick <= 1'b0;
        end else if (r_cnt == LP_WRAP) begin
            r_cnt  <= 8'd0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 8'd1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver, 8x oversampled, valid/ack byte handshake
module uart_rx
    import uart_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEFAULT,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       user_clock,
    input  logic       rst,
    input  logic       usb_rs232_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_error,
    output logic       overrun,
    output logic       rx_busy
);

    // The start-bit check fires on the tick that advances os_cnt to
    // MID_SAMPLE, i.e. while os_cnt still holds MID_SAMPLE-1. Data and stop
    // bits are then sampled every OVERSAMPLE ticks from that point.
    localparam logic [2:0] LP_START_CHK = 3'(MID_SAMPLE - 1);
    localparam logic [2:0] LP_OS_LAST   = 3'(OVERSAMPLE - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        w_rxs;
    logic        w_tick;
    uart_state_t r_state;
    logic [2:0]  r_os_cnt;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_frame_error;
    logic        r_overrun;
    logic        r_busy;
    logic        r_armed;

    uart_baud_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .user_clock (user_clock),
        .rst        (rst),
        .tick       (w_tick)
    );

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge user_clock or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= usb_rs232_rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs     = r_sync2;
    assign w_bit_idx = MSB_FIRST ? ~r_bit_cnt : r_bit_cnt;

    // Receive FSM with handshake, error flags and registered outputs
    always_ff @(posedge user_clock or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_os_cnt      <= 3'd0;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'h00;
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
            r_armed       <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;

            // A line still low when reset is released is not a start bit;
            // start detection is only enabled once the line has been high.
            if (w_rxs) begin
                r_armed <= 1'b1;
            end

            // Acknowledge; a byte load later in this block takes priority
            if (rx_ack && r_rx_valid) begin
                r_rx_valid <= 1'b0;
                r_overrun  <= 1'b0;
            end

            if (w_tick) begin
                case (r_state)
                    IDLE: begin
                        if (!w_rxs && r_armed) begin
                            r_state  <= START;
                            r_os_cnt <= 3'd0;
                            r_busy   <= 1'b1;
                        end
                    end
                    START: begin
                        if (r_os_cnt == LP_START_CHK) begin
                            if (w_rxs) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state   <= DATA;
                                r_os_cnt  <= 3'd0;
                                r_bit_cnt <= 3'd0;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 3'd1;
                        end
                    end
                    DATA: begin
                        if (r_os_cnt == LP_OS_LAST) begin
                            r_shift[w_bit_idx] <= w_rxs;
                            r_os_cnt           <= 3'd0;
                            r_bit_cnt          <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= STOP;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 3'd1;
                        end
                    end
                    STOP: begin
                        if (r_os_cnt == LP_OS_LAST) begin
                            r_os_cnt <= 3'd0;
                            if (w_rxs) begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                                if (r_rx_valid && !rx_ack) begin
                                    r_overrun <= 1'b1;
                                end
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_frame_error <= 1'b1;
                                r_state       <= BREAK;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 3'd1;
                        end
                    end
                    BREAK: begin
                        if (w_rxs) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;
    assign rx_busy     = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int BIT_CLKS = 344;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       overrun;
    logic       rx_busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   edge_cyc = 0;
    int   fe_cnt = 0;
    logic prev_valid = 1'b0;

    uart_rx #(
        .TICK_DIV  (43),
        .MSB_FIRST (1'b0)
    ) dut (
        .user_clock    (clk),
        .rst           (rst),
        .usb_rs232_rxd (rxd),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ack        (rx_ack),
        .frame_error   (frame_error),
        .overrun       (overrun),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) rise_cyc <= cyc;
        prev_valid <= rx_valid;
        if (frame_error) fe_cnt <= fe_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        @(negedge clk);
        edge_cyc = cyc;
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (BIT_CLKS - 1) @(negedge clk);
    endtask

    task automatic do_ack;
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({rx_data, rx_valid, frame_error, overrun, rx_busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h valid=%b fe=%b ovr=%b busy=%b want all 0",
                     rx_data, rx_valid, frame_error, overrun, rx_busy);
        end
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        checks++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b valid=%b want 0 0", rx_busy, rx_valid);
        end
    endtask

    task automatic test_single;
        int lat;
        send_byte(8'h5A, 1'b1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
            errors++;
            $display("FAIL single_byte: got valid=%b data=%h want 1 5a", rx_valid, rx_data);
        end
        lat = rise_cyc - edge_cyc;
        checks++;
        if (lat < 3200 || lat > 3300) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles want 3200..3300", lat);
        end
        do_ack;
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: got valid=%b want 0", rx_valid);
        end
    endtask

    task automatic test_false_start;
        int   fe0;
        logic seen_busy;
        fe0 = fe_cnt;
        seen_busy = 1'b0;
        for (int i = 0; i < 516; i++) begin
            rxd = (i < 100) ? 1'b0 : 1'b1;
            @(negedge clk);
            seen_busy = seen_busy | rx_busy;
        end
        checks++;
        if (seen_busy !== 1'b1) begin
            errors++;
            $display("FAIL false_start_busy_seen: got %b want 1", seen_busy);
        end
        checks++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || fe_cnt != fe0) begin
            errors++;
            $display("FAIL false_start: got busy=%b valid=%b fe_pulses=%0d want 0 0 0",
                     rx_busy, rx_valid, fe_cnt - fe0);
        end
    endtask

    task automatic test_framing;
        int fe0;
        fe0 = fe_cnt;
        send_byte(8'hA5, 1'b0);
        rxd = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        checks++;
        if (fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL frame_error_count: got %0d want 1", fe_cnt - fe0);
        end
        checks++;
        if (rx_valid !== 1'b0 || rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_break_state: got valid=%b busy=%b want 0 1", rx_valid, rx_busy);
        end
        rxd = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_recover_idle: got busy=%b want 0", rx_busy);
        end
        send_byte(8'h3C, 1'b1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C || fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL frame_recover_byte: got valid=%b data=%h fe=%0d want 1 3c 1",
                     rx_valid, rx_data, fe_cnt - fe0);
        end
        do_ack;
    endtask

    task automatic test_overrun;
        send_byte(8'h11, 1'b1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_first: got valid=%b data=%h ovr=%b want 1 11 0",
                     rx_valid, rx_data, overrun);
        end
        send_byte(8'h22, 1'b1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h22 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_second: got valid=%b data=%h ovr=%b want 1 22 1",
                     rx_valid, rx_data, overrun);
        end
        do_ack;
        checks++;
        if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_ack: got valid=%b ovr=%b want 0 0", rx_valid, overrun);
        end
    endtask

    task automatic test_collision;
        int target;
        send_byte(8'h33, 1'b1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h33) begin
            errors++;
            $display("FAIL collide_first: got valid=%b data=%h want 1 33", rx_valid, rx_data);
        end
        // Next frame starts exactly 80 ticks later, so it loads 3440 cycles after this one
        target = rise_cyc + 10 * BIT_CLKS;
        fork
            send_byte(8'h44, 1'b1);
            begin
                while (cyc < target - 1) @(negedge clk);
                checks++;
                if (rx_valid !== 1'b1 || rx_data !== 8'h33) begin
                    errors++;
                    $display("FAIL collide_preload: got valid=%b data=%h want 1 33",
                             rx_valid, rx_data);
                end
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
                checks++;
                if (rx_valid !== 1'b1 || rx_data !== 8'h44 || overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL collide_load: got valid=%b data=%h ovr=%b want 1 44 0",
                             rx_valid, rx_data, overrun);
                end
            end
        join
        do_ack;
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        d = 8'hF3;
        @(negedge clk);
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd = d[4];
        repeat (172) @(negedge clk);
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy_before: got %b want 1", rx_busy);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        checks++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_cleared: got busy=%b valid=%b want 0 0", rx_busy, rx_valid);
        end
        repeat (168) @(negedge clk);
        for (int i = 5; i < 8; i++) begin
            rxd = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_lost: got valid=%b busy=%b want 0 0", rx_valid, rx_busy);
        end
        send_byte(8'h96, 1'b1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h96 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next: got valid=%b data=%h ovr=%b want 1 96 0",
                     rx_valid, rx_data, overrun);
        end
        do_ack;
    endtask

    initial begin
        test_reset;
        test_single;
        test_false_start;
        test_framing;
        test_overrun;
        test_collision;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
